// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enabled single-port RAM: FSM encoding,
// byte width and the lane-count helper.
package ram_pkg;

  localparam int BYTE_W = 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_lane_parity.sv
// Combinational even-parity generator: one bit per byte lane of a data word,
// so that each lane plus its parity bit holds an even number of ones.
module ram_lane_parity
  import ram_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]        data,
  output logic [DATA_W/BYTE_W-1:0] par
);

  for (genvar i = 0; i < DATA_W / BYTE_W; i++) begin : g_lane
    assign par[i] = ^data[i*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with byte-lane writes, registered read with a
// valid strobe and a clear sweep; optional per-lane parity under RAM_PARITY_EN.
module ram_sp_be
  import ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     rvalid,
  output logic                     perr
);

  localparam int LANES = lane_count(DATA_W);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  logic [0:0]        state;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              in_range;
  logic              do_wr;
  logic              do_rd;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rdata;
  logic              rd_perr;

  assign idle     = (state == ST_IDLE);
  assign busy     = ~idle;
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign idx      = addr[AW-1:0];
  assign do_wr    = idle & wen & in_range;
  assign do_rd    = idle & ren;
  assign rdata    = mem[idx];

  // Sweep pointer restarts at zero on reset and on a clear request taken in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

`ifdef RAM_PARITY_EN
  logic [LANES-1:0] pmem [DEPTH];
  logic [LANES-1:0] wpar;
  logic [LANES-1:0] rpar;

  ram_lane_parity #(.DATA_W(DATA_W)) u_wr_parity (.data(din),   .par(wpar));
  ram_lane_parity #(.DATA_W(DATA_W)) u_rd_parity (.data(rdata), .par(rpar));

  assign rd_perr = |(rpar ^ pmem[idx]);

  // Parity bits follow their lanes: only written lanes get fresh parity.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!idle) begin
        pmem[ptr] <= '0;
      end else if (do_wr) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) pmem[idx][i] <= wpar[i];
        end
      end
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  // Array itself has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!idle) begin
        mem[ptr] <= '0;
      end else if (do_wr) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[idx][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read-first: rdata is sampled before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      rvalid <= 1'b0;
      perr   <= 1'b0;
    end else begin
      rvalid <= do_rd;
      perr   <= do_rd & in_range & rd_perr;
      if (do_rd) begin
        dout <= in_range ? rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_be.sv
// Directed self-checking bench for ram_sp_be (DEPTH=16 build); parity checks
// are exercised when RAM_PARITY_EN is defined.
module tb_ram_sp_be;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        wen   = 1'b0;
  logic        ren   = 1'b0;
  logic [1:0]  be    = '0;
  logic [7:0]  addr  = '0;
  logic [15:0] din   = '0;
  logic        busy;
  logic [15:0] dout;
  logic        rvalid;
  logic        perr;

  int vectors     = 0;
  int miscompares = 0;

  ram_sp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .wen(wen), .ren(ren), .be(be), .addr(addr), .din(din),
    .dout(dout), .rvalid(rvalid), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and return just after the edge that samples them.
  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] b,
                               input logic [7:0] a, input logic [15:0] d, input logic c);
    wen = w; ren = r; be = b; addr = a; din = d; clr = c;
    waitCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b0);
  endtask

  task automatic readCheck(input logic [7:0] a, input logic [15:0] exp, input string tag);
    applyStimulus(1'b0, 1'b1, 2'b00, a, 16'h0, 1'b0);
    checkOutput({tag, "_dout"}, 32'(dout), 32'(exp));
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd1);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      waitCycle();
    end
  endtask

  int n;

  initial begin
    repeat (3) waitCycle();
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_perr", 32'(perr), 32'd0);

    rst_n = 1'b1;
    countBusy(n);
    checkOutput("init_clear_len", 32'(n), 32'(DEPTH));

    for (int i = 0; i < DEPTH; i++) begin
      readCheck(8'(i), 16'h0000, $sformatf("init_rd%0d", i));
      checkOutput($sformatf("init_perr%0d", i), 32'(perr), 32'd0);
    end
    idleCycle();
    checkOutput("rvalid_drop", 32'(rvalid), 32'd0);

    // Byte-lane merge, mask of zero, and dout hold.
    applyStimulus(1'b1, 1'b0, 2'b11, 8'd5, 16'hBEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 8'd5, 16'h12AB, 1'b0);
    readCheck(8'd5, 16'h12EF, "be_merge");
    idleCycle();
    checkOutput("be_rvalid_once", 32'(rvalid), 32'd0);
    checkOutput("dout_hold", 32'(dout), 32'h12EF);
    applyStimulus(1'b1, 1'b0, 2'b00, 8'd5, 16'hFFFF, 1'b0);
    readCheck(8'd5, 16'h12EF, "be_none");

    // Same-cycle write and read returns old contents.
    applyStimulus(1'b1, 1'b0, 2'b11, 8'd3, 16'h1111, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd3, 16'h2222, 1'b0);
    checkOutput("rw_same_dout", 32'(dout), 32'h1111);
    readCheck(8'd3, 16'h2222, "rw_after");

    // Fill, then clear with a read accepted alongside the request.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b11, 8'(i), 16'hA000 + 16'(i), 1'b0);
    end
    readCheck(8'd9, 16'hA009, "fill_rd9");
    applyStimulus(1'b0, 1'b1, 2'b00, 8'd7, 16'h0, 1'b1);
    checkOutput("clr_busy_rise", 32'(busy), 32'd1);
    checkOutput("clr_rd_dout", 32'(dout), 32'hA007);
    checkOutput("clr_rd_rvalid", 32'(rvalid), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 1) begin
        clr = 1'b0; wen = 1'b1; ren = 1'b1; be = 2'b11; addr = 8'd2; din = 16'hFFFF;
      end else if (n == 2) begin
        checkOutput("busy_rvalid", 32'(rvalid), 32'd0);
        checkOutput("busy_dout_hold", 32'(dout), 32'hA007);
        wen = 1'b0; ren = 1'b0;
      end else if (n == 4) begin
        clr = 1'b1;
      end else if (n == 5) begin
        clr = 1'b0;
      end
      waitCycle();
    end
    checkOutput("clr_len", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      readCheck(8'(i), 16'h0000, $sformatf("clr_rd%0d", i));
    end

    // Reset in the middle of a sweep restarts it from zero.
    applyStimulus(1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1);
    repeat (7) idleCycle();
    rst_n = 1'b0;
    repeat (2) waitCycle();
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    checkOutput("midrst_rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    countBusy(n);
    checkOutput("midrst_clear_len", 32'(n), 32'(DEPTH));

    // Out-of-range: read gives zero, write must not alias onto a low address.
    applyStimulus(1'b1, 1'b0, 2'b11, 8'd4, 16'h7777, 1'b0);
    readCheck(8'd4, 16'h7777, "oor_pre");
    readCheck(8'd20, 16'h0000, "oor_rd");
    checkOutput("oor_perr", 32'(perr), 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b11, 8'd20, 16'hABCD, 1'b0);
    readCheck(8'd4, 16'h7777, "oor_noalias");

    // Back-to-back reads keep rvalid high.
    readCheck(8'd4, 16'h7777, "b2b_0");
    readCheck(8'd5, 16'h0000, "b2b_1");

    applyStimulus(1'b1, 1'b0, 2'b11, 8'd9, 16'h00FF, 1'b0);
    readCheck(8'd9, 16'h00FF, "par_clean");
    checkOutput("par_clean_perr", 32'(perr), 32'd0);
`ifdef RAM_PARITY_EN
    dut.mem[9][0] = ~dut.mem[9][0];
    readCheck(8'd9, 16'h00FE, "par_flip");
    checkOutput("par_flip_perr", 32'(perr), 32'd1);
    idleCycle();
    checkOutput("par_perr_drop", 32'(perr), 32'd0);
`else
    readCheck(8'd9, 16'h00FF, "nopar_rd");
    checkOutput("nopar_perr", 32'(perr), 32'd0);
`endif
    idleCycle();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_sp_be.md
Name: ram_sp_be

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 16-bit data memory.
- Adds per-byte write enables, a registered read with a valid strobe, and a hardware clear sequencer (runs after reset and on request).
- Busy/handshake output so the CPU core stalls memory access during clear.
- Sits between the core's load/store unit and the data address space.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, address bus width in bits.
- DEPTH, 65536, number of words implemented; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle request to zero the whole array.
- busy  out  1  high while the clear sequencer runs; accesses ignored.
- wen  in  1  write enable.
- ren  in  1  read enable.
- be  in  DATA_W/8  byte-lane write mask; bit i covers din[8i+7:8i].
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle strobe: dout holds fresh read data.
- perr  out  1  parity error flag, qualified by rvalid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM forced to CLEAR with sweep pointer 0.
  - dout=0, rvalid=0, perr=0, busy=1.
  - Array contents are not touched asynchronously.
- FSM has two states:
  - CLEAR: writes all-zero (parity included) to word[ptr] each cycle and increments ptr. When ptr==DEPTH-1 is written, next state is IDLE and busy falls. Clear takes exactly DEPTH cycles after rst_n rises.
  - IDLE: normal access. clr=1 moves to CLEAR with ptr=0, and busy rises the next cycle.
- clr while in CLEAR is ignored; the sweep is not restarted.
- wen, ren and be are ignored while busy=1. rvalid stays 0 during busy.
- Any request accepted in the same cycle clr is sampled in IDLE still completes: the write is performed (then zeroed by the sweep), and the read returns its data.
- Write (IDLE, wen=1, addr<DEPTH): at the rising edge, lanes with be[i]=1 take din, and lanes with be[i]=0 keep their contents. If be is all zeros, no change.
- Read (IDLE, ren=1): dout and rvalid update at the edge where ren is sampled; rvalid=1 for exactly that following cycle.
- dout holds its last value when no read completes; it is not zeroed.
- Read and write to the same address in the same cycle: read-first, so dout returns the pre-write contents.
- addr >= DEPTH:
  - Write is dropped.
  - Read returns dout=0 with rvalid=1 and perr=0.
- Back-to-back reads give one result per cycle; rvalid stays high continuously.
- Reset mid-clear or mid-read: the async reset wins, and the clear restarts from 0 after release.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per byte lane, updated only for written lanes.
  - On read, perr=1 alongside rvalid if any lane's stored parity mismatches recomputed parity.
  - Clear writes parity 0.
- Undefined: no parity storage; perr tied 0.

Decomposition:
- Package ram_pkg holds:
  - FSM state encoding ST_CLEAR, ST_IDLE.
  - BYTE_W=8.
  - Function computing lane count DATA_W/BYTE_W.
- One sub-module, ram_lane_parity: DATA_W in, DATA_W/8 even-parity bits out, purely combinational. Instanced on the write path and the read path only under RAM_PARITY_EN.

Test Plan:
- Release rst_n, no stimulus: busy=1 for exactly DEPTH cycles (DEPTH=16 build: 16 cycles), then 0. Read of every address returns 0 with rvalid and perr=0.
- Write 0xBEEF at addr 5 with be=2'b11, then write 0x12xx with be=2'b10, then read addr 5: dout=0x12EF, rvalid high exactly 1 cycle after ren.
- Same-cycle wen+ren at addr 3 (old 0x1111, din 0x2222): dout=0x1111. Next read gives 0x2222.
- Pulse clr after filling memory: busy rises next cycle. wen/ren during busy are ignored with rvalid=0. Afterwards all words read 0. A second clr mid-sweep does not extend busy.
- Assert rst_n low mid-clear at ptr=7 and release: busy lasts a full DEPTH cycles again. Read at addr >= DEPTH (DEPTH=16, addr 20): dout=0, rvalid=1.
- With RAM_PARITY_EN, force-flip a stored data bit in lane 0 via hierarchical deposit, then read: perr=1 with rvalid. Without the macro, perr stays 0.
